// File: rtl/md_pkg.sv
// Shared encodings, FSM states and a sign helper for the iterative
// multiply/divide unit.
package md_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_RSVD  = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } md_state_e;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/md_sign_cond.sv
// Combinational sign conditioner: optional abs() of a signed operand and an
// optional two's-complement negate, applied as a single conditional negate.
module md_sign_cond #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         abs_en,
  input  logic         neg_en,
  output logic [W-1:0] res
);

  logic flip;

  assign flip = (abs_en & val[W-1]) ^ neg_en;
  assign res  = flip ? (~val + W'(1)) : val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: one shift-add or restoring
// subtract step per cycle, with sign fix-up in a final cycle.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2 * WIDTH + 1;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dzero_q, dzero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             signed_op;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] post_in, post_out;

  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    div_shift;
  logic [WIDTH+1:0] div_diff;

  assign signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);

  md_sign_cond #(.W(WIDTH)) u_pre_a (
    .val(data1), .abs_en(signed_op), .neg_en(1'b0), .res(mag_a)
  );

  md_sign_cond #(.W(WIDTH)) u_pre_b (
    .val(data2), .abs_en(signed_op), .neg_en(1'b0), .res(mag_b)
  );

  // Quotient is fed zero-extended so one wide negator serves both op kinds.
  assign post_in = is_div_q ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q[2*WIDTH-1:0];

  md_sign_cond #(.W(2*WIDTH)) u_post (
    .val(post_in), .abs_en(1'b0), .neg_en(neg_res_q), .res(post_out)
  );

  always_comb begin
    mul_sum   = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                         : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    div_shift = {acc_q[AW-2:0], 1'b0};
    div_diff  = {1'b0, div_shift[AW-1:WIDTH]} - {2'b00, opnd_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dzero_d   = dzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!flush) begin
          case (md_op_e'(md_op))
            MD_MTHI: hi_d = data1;
            MD_MTLO: lo_d = data1;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              is_div_d  = (md_op == MD_DIV) || (md_op == MD_DIVU);
              // Multiplier sits in the low half; dividend shifts out of it.
              acc_d     = {{(WIDTH+1){1'b0}}, is_div_d ? mag_a : mag_b};
              opnd_d    = is_div_d ? mag_b : mag_a;
              neg_res_d = signed_op & (data1[WIDTH-1] ^ data2[WIDTH-1]);
              neg_rem_d = signed_op & data1[WIDTH-1];
              dzero_d   = is_div_d && (data2 == '0);
              cnt_d     = CW'(WIDTH - 1);
              state_d   = S_RUN;
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = div_diff[WIDTH+1] ? div_shift
                                      : {div_diff[WIDTH:0], div_shift[WIDTH-1:1], 1'b1};
          end else begin
            acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
          end
          if (cnt_q == '0) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_FINISH: begin
        if (!flush) begin
          if (is_div_q) begin
            lo_d = dzero_q ? {WIDTH{1'b1}} : post_out[WIDTH-1:0];
            hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
          end else begin
            hi_d = post_out[2*WIDTH-1:WIDTH];
            lo_d = post_out[WIDTH-1:0];
          end
        end else begin
          hi_d = hi_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dzero_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dzero_q   <= dzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a vector table of MD ops plus hand-built
// sequences for MTHI, busy-time requests, flush and mid-op reset.
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  md_op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks_total = 0;
  int checks_pass  = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .md_op(md_op), .data1(data1), .data2(data2),
    .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Present a request for one cycle (cycle 0); returns just after its edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_op = op;
    data1 = a;
    data2 = b;
    @(posedge clk);
    #1;
    md_op = 3'b000;
  endtask

  // Follow an accepted op through cycles 1..34 and check timing and result.
  task automatic follow(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int done_at;
    int done_cnt;
    logic busy_ok;
    done_at  = -1;
    done_cnt = 0;
    busy_ok  = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k <= 33 && !busy) busy_ok = 1'b0;
      if (k == 34) begin
        chk({name, " busy_low_c34"}, {31'd0, busy}, 32'd0);
        chk({name, " hi"}, hi, exp_hi);
        chk({name, " lo"}, lo, exp_lo);
      end
    end
    chk({name, " done_cycle"}, done_at, 32'd33);
    chk({name, " done_pulses"}, done_cnt, 32'd1);
    chk({name, " busy_1_33"}, {31'd0, busy_ok}, 32'd1);
  endtask

  initial begin
    int  done_seen;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;

    vecs[0] = '{"mult_m1x5",   3'b001, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[1] = '{"multu_max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{"div_m7_2",    3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"divu_100_7",  3'b100, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[4] = '{"div_by_zero", 3'b011, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[5] = '{"div_ovf",     3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{"mult_min_sq", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7] = '{"divu_max_16", 3'b100, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[8] = '{"div_7_m2",    3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

    rst   = 1'b1;
    md_op = 3'b000;
    data1 = 32'd0;
    data2 = 32'd0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      follow(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // MTHI in IDLE: hi updates next edge, lo untouched, no done, stays idle.
    hold_lo = lo;
    issue(3'b101, 32'hA5A5A5A5, 32'd0);
    chk("mthi hi", hi, 32'hA5A5A5A5);
    chk("mthi lo", lo, hold_lo);
    chk("mthi done", {31'd0, done}, 32'd0);
    chk("mthi busy", {31'd0, busy}, 32'd0);

    // MTLO and MULT arriving while busy must be ignored.
    issue(3'b010, 32'h00000003, 32'h00000004);
    done_seen = -1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (done && done_seen < 0) done_seen = k;
      if (k == 5) begin md_op = 3'b110; data1 = 32'hDEADBEEF; end
      if (k == 6) begin md_op = 3'b001; data1 = 32'h00000007; data2 = 32'h00000007; end
      if (k == 7) md_op = 3'b000;
    end
    chk("busy_ign done_cycle", done_seen, 32'd33);
    chk("busy_ign hi", hi, 32'h00000000);
    chk("busy_ign lo", lo, 32'h0000000C);
    chk("busy_ign busy", {31'd0, busy}, 32'd0);

    // Flush in cycle 10 of a DIV.
    hold_hi = hi;
    hold_lo = lo;
    issue(3'b011, 32'h00000064, 32'h00000007);
    done_seen = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (k == 10) flush = 1'b1;
      if (k == 11) begin
        flush = 1'b0;
        chk("flush busy", {31'd0, busy}, 32'd0);
        chk("flush hi", hi, hold_hi);
        chk("flush lo", lo, hold_lo);
      end
    end
    repeat (30) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("flush no_done", done_seen, 32'd0);

    // Request right after a flush is accepted.
    issue(3'b100, 32'h00000064, 32'h00000007);
    follow("post_flush_divu", 32'h00000002, 32'h0000000E);

    // Flush in IDLE drops a same-cycle request.
    @(negedge clk);
    md_op = 3'b101;
    data1 = 32'h12345678;
    flush = 1'b1;
    @(negedge clk);
    md_op = 3'b000;
    flush = 1'b0;
    chk("idle_flush hi", hi, 32'h00000002);
    chk("idle_flush busy", {31'd0, busy}, 32'd0);

    // Reset (together with flush) in cycle 5 of a MULT.
    issue(3'b001, 32'h00000005, 32'h00000006);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) begin rst = 1'b1; flush = 1'b1; end
      if (k == 6) begin
        chk("rst_mid busy", {31'd0, busy}, 32'd0);
        chk("rst_mid done", {31'd0, done}, 32'd0);
        chk("rst_mid hi", hi, 32'd0);
        chk("rst_mid lo", lo, 32'd0);
        rst   = 1'b0;
        flush = 1'b0;
      end
    end

    // Unit is usable again after the mid-op reset.
    issue(3'b001, 32'h00000005, 32'hFFFFFFFA);
    follow("after_rst_mult", 32'hFFFFFFFF, 32'hFFFFFFE2);

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
